mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the Pipelined_Processor's single external data-memory port (MemRead/MemWrite/MemAddr/MemData/MemOutput) between the pipeline MEM stage (D) and an external debug/loader master (X). D has fixed priority. A starvation counter bounds X's wait time. The block issues one registered bus transaction per cycle and returns read data, tagged to its owner, two edges after acceptance. It sits between the processor core and the memory model, replacing the core's direct drive of the memory bus.

## Interface
- DataWidth, 16: data and address width in bits.
- StarveMax, 4: maximum consecutive cycles a waiting X request loses to D. Legal range 1..15.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous reset, active-low (asserted at 0).
- d_req, d_we  in  1 each  D request; 1 = write.
- d_addr, d_wdata  in  DataWidth each  D address and write data.
- d_stall  out  1  D request pending and not granted this cycle.
- d_rvalid  out  1  D read data valid, one-cycle pulse.
- d_rdata  out  DataWidth  D read data.
- x_req, x_we  in  1 each  X request; 1 = write.
- x_addr, x_wdata  in  DataWidth each  X address and write data.
- x_gnt  out  1  X request accepted this cycle.
- x_rvalid  out  1  X read data valid, one-cycle pulse.
- x_rdata  out  DataWidth  X read data.
- MemRead, MemWrite  out  1 each  registered memory strobes.
- MemAddr, MemData  out  DataWidth each  registered memory address and write data.
- MemOutput  in  DataWidth  memory read data, valid the cycle after MemRead.

## Operation
- Grant (combinational, each cycle):
  - X wins if x_req is high and x_wait == StarveMax.
  - Otherwise D wins if d_req is high.
  - Otherwise X wins if x_req is high.
- Outputs from the grant:
  - d_stall = d_req & ~grant_D.
  - x_gnt = grant_X.
- Requesters hold req and all request fields stable until granted (D: until d_stall is low; X: until x_gnt is high).
- Accepted transaction: at the accepting edge, MemRead (read) or MemWrite (write) is registered high, MemAddr gets the address, and MemData gets the write data. MemData is 0 on reads.
- No grant: all four bus outputs register to 0.
- Reads: the owner tag (OWN_D/OWN_X) and a valid bit travel through a one-stage tracking register. At the next edge, MemOutput is captured into d_rdata or x_rdata according to the tag, and the matching rvalid pulses for one cycle. The other requester's rdata holds its previous value.
- Writes produce no rvalid.
- x_wait counter:
  - Increments, saturating at StarveMax, on every edge where x_req is high and x_gnt is low.
  - Clears to 0 on X grant or when x_req is low.
- Only the request selects the cycle's owner. Back-to-back transactions of any mix issue every cycle with no bubbles.

## Timing
- Reset values: every output 0, tracking valid 0, x_wait 0. Reset is asynchronous.
- Read latency:
  - Accept at edge k.
  - Bus active in cycle k→k+1.
  - MemOutput sampled at edge k+1.
  - rvalid/rdata high in cycle k+1→k+2.
- Write: bus active in cycle k→k+1 only.
- Simultaneous D and X requests with x_wait < StarveMax: D granted, x_wait increments.
- With d_req held continuously, X waits at most StarveMax cycles and is granted on cycle StarveMax+1. D stalls exactly that one cycle.
- Reset mid-read: in-flight tag and valid are discarded. No rvalid after RST deasserts until a new read is accepted.
- No internal combinational path from MemOutput to any output; rdata and rvalid are registered.

## Structure
- Package mem_arb_pkg: owner_t enum (OWN_NONE, OWN_D, OWN_X), DATA_W = 16, and the x_wait width function (clog2(StarveMax+1)).
- One sub-module, mem_arb_starve_ctr: the saturating x_wait counter with clear/increment inputs and an at_max output.
- Grant logic, bus registers and read-return tracking live in mem_port_arbiter.

## Test plan
- Reset, then hold RST low for 3 cycles with requests active → every output 0 throughout; no MemRead/MemWrite.
- D read, addr 0x0010, memory returns 0x1234 → d_stall 0; MemRead=1 and MemAddr=0x0010 one cycle after accept; d_rvalid=1 and d_rdata=0x1234 the following cycle; x_rvalid stays 0.
- D write 0x00A5 to 0x0020 and X read of 0x0030 in the same cycle → MemWrite/MemData=0x00A5 first, x_gnt the next cycle, then MemRead at 0x0030 and an x_rvalid pulse; no d_rvalid.
- StarveMax=4, d_req and x_req held high for 10 cycles → D owns 4 cycles, X is granted on cycle 5 (d_stall=1 only then), D resumes, and x_wait returns to 0.
- Alternating D/X reads every cycle with MemOutput = address+1 → each rvalid pulses on the correct side with matching data; zero bubble cycles on MemRead.
- RST pulsed low in the cycle between MemRead and data return → no rvalid after release; the next read returns normally with 2-edge latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int DATA_W = 16;

    // Owner of an in-flight read, carried alongside the tracking valid bit.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_X    = 2'd2
    } owner_t;

    // Bits needed to hold a wait count of 0..starve_max inclusive.
    function automatic int x_wait_width(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating wait counter for the debug/loader master. Counts cycles a
// pending X request loses arbitration; at_max_o forces the next grant to X.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int StarveMax = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int CntW = x_wait_width(StarveMax);
    localparam logic [CntW-1:0] MaxCnt = CntW'(StarveMax);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear wins over increment; increment stops at MaxCnt.
    always_comb begin
        // NOTE: assign a default first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MaxCnt)) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max_o = (count_q == MaxCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered data-memory port between the pipeline MEM stage (D,
// fixed priority) and a debug/loader master (X, starvation-bounded). One bus
// transaction issues per cycle; read data returns to its owner two edges
// after acceptance.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int StarveMax = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [DataWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    output logic                 d_stall,
    output logic                 d_rvalid,
    output logic [DataWidth-1:0] d_rdata,
    input  logic                 x_req,
    input  logic                 x_we,
    input  logic [DataWidth-1:0] x_addr,
    input  logic [DataWidth-1:0] x_wdata,
    output logic                 x_gnt,
    output logic                 x_rvalid,
    output logic [DataWidth-1:0] x_rdata,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [DataWidth-1:0] MemAddr,
    output logic [DataWidth-1:0] MemData,
    input  logic [DataWidth-1:0] MemOutput
);

    logic grant_d, grant_x, x_at_max;

    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [DataWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_data_q, mem_data_d;
    logic                 trk_valid_q, trk_valid_d;
    owner_t               trk_own_q, trk_own_d;

    logic                 d_rvalid_q, x_rvalid_q;
    logic [DataWidth-1:0] d_rdata_q, x_rdata_q;

    mem_arb_starve_ctr #(
        .StarveMax (StarveMax)
    ) u_starve_ctr (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .clr_i    (~x_req | grant_x),
        .inc_i    (x_req & ~grant_x),
        .at_max_o (x_at_max)
    );

    // Grant: a starved X beats D; otherwise D has priority over X.
    always_comb begin
        grant_x = x_req & (x_at_max | ~d_req);
        grant_d = d_req & ~grant_x;
    end

    assign d_stall = d_req & ~grant_d;
    assign x_gnt   = grant_x;

    // Next bus cycle and read-tracking entry from the winning request.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
        trk_valid_d = 1'b0;
        trk_own_d   = OWN_NONE;
        if (grant_d) begin
            mem_read_d  = ~d_we;
            mem_write_d = d_we;
            mem_addr_d  = d_addr;
            mem_data_d  = d_we ? d_wdata : '0;
            trk_valid_d = ~d_we;
            trk_own_d   = OWN_D;
        end else if (grant_x) begin
            mem_read_d  = ~x_we;
            mem_write_d = x_we;
            mem_addr_d  = x_addr;
            mem_data_d  = x_we ? x_wdata : '0;
            trk_valid_d = ~x_we;
            trk_own_d   = OWN_X;
        end
    end

    // Bus and tracking registers; reset drops any in-flight read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            trk_valid_q <= 1'b0;
            trk_own_q   <= OWN_NONE;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            trk_valid_q <= trk_valid_d;
            trk_own_q   <= trk_own_d;
        end
    end

    // Read return: capture MemOutput into the tagged owner's data register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_rvalid_q <= 1'b0;
            x_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            x_rdata_q  <= '0;
        end else begin
            d_rvalid_q <= trk_valid_q && (trk_own_q == OWN_D);
            x_rvalid_q <= trk_valid_q && (trk_own_q == OWN_X);
            if (trk_valid_q && (trk_own_q == OWN_D)) begin
                d_rdata_q <= MemOutput;
            end
            if (trk_valid_q && (trk_own_q == OWN_X)) begin
                x_rdata_q <= MemOutput;
            end
        end
    end

    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign MemAddr  = mem_addr_q;
    assign MemData  = mem_data_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign x_rvalid = x_rvalid_q;
    assign x_rdata  = x_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a combinational memory model.
module tb_mem_port_arbiter;

    localparam int DW = 16;
    localparam int SM = 4;

    logic          CLK, RST;
    logic          d_req, d_we, d_stall, d_rvalid;
    logic [DW-1:0] d_addr, d_wdata, d_rdata;
    logic          x_req, x_we, x_gnt, x_rvalid;
    logic [DW-1:0] x_addr, x_wdata, x_rdata;
    logic          MemRead, MemWrite;
    logic [DW-1:0] MemAddr, MemData, MemOutput;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DataWidth(DW), .StarveMax(SM)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_stall   (d_stall),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .x_gnt     (x_gnt),
        .x_rvalid  (x_rvalid),
        .x_rdata   (x_rdata),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemOutput (MemOutput)
    );

    // Memory model: two fixed locations, everything else reads as address+1.
    function automatic logic [DW-1:0] model_rd(input logic [DW-1:0] a);
        case (a)
            16'h0010: return 16'h1234;
            16'h0030: return 16'hBEEF;
            default:  return a + 16'h0001;
        endcase
    endfunction

    assign MemOutput = model_rd(MemAddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".strobes"}, {26'd0, d_stall, x_gnt, d_rvalid, x_rvalid, MemRead, MemWrite}, 32'd0);
        check({tag, ".addr"},    {16'd0, MemAddr}, 32'd0);
        check({tag, ".data"},    {16'd0, MemData}, 32'd0);
        check({tag, ".rdata"},   {d_rdata, x_rdata}, 32'd0);
    endtask

    function automatic logic [DW-1:0] alt_addr(input int i);
        return (i % 2 == 0) ? DW'(16'h0100 + i) : DW'(16'h0200 + i);
    endfunction

    initial begin
        RST = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0011; d_wdata = 16'h5555;
        x_req = 1'b1; x_we = 1'b1; x_addr = 16'h0022; x_wdata = 16'hAAAA;

        // Reset held with both requests active.
        for (int r = 0; r < 3; r++) begin
            tick();
            check_all_zero("reset");
        end
        d_req = 1'b0; x_req = 1'b0;
        RST = 1'b1;
        tick();

        // D read of 0x0010.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        #1 check("drd.stall", {31'd0, d_stall}, 32'd0);
        tick();
        d_req = 1'b0;
        check("drd.memread", {31'd0, MemRead}, 32'd1);
        check("drd.memaddr", {16'd0, MemAddr}, 32'h0010);
        check("drd.memdata", {16'd0, MemData}, 32'h0000);
        tick();
        check("drd.rvalid", {30'd0, d_rvalid, x_rvalid}, 32'b10);
        check("drd.rdata", {16'd0, d_rdata}, 32'h1234);
        tick();
        check("drd.pulse", {30'd0, d_rvalid, x_rvalid}, 32'b00);
        check("drd.hold", {16'd0, d_rdata}, 32'h1234);

        // D write and X read together: D first, then X.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h00A5;
        x_req = 1'b1; x_we = 1'b0; x_addr = 16'h0030;
        #1 check("mix.grant0", {30'd0, d_stall, x_gnt}, 32'b00);
        tick();
        d_req = 1'b0;
        check("mix.write", {30'd0, MemWrite, MemRead}, 32'b10);
        check("mix.waddr", {MemAddr, MemData}, {16'h0020, 16'h00A5});
        #1 check("mix.xgnt", {31'd0, x_gnt}, 32'd1);
        tick();
        x_req = 1'b0;
        check("mix.read", {30'd0, MemWrite, MemRead}, 32'b01);
        check("mix.raddr", {MemAddr, MemData}, {16'h0030, 16'h0000});
        check("mix.norv", {30'd0, d_rvalid, x_rvalid}, 32'b00);
        tick();
        check("mix.rvalid", {30'd0, d_rvalid, x_rvalid}, 32'b01);
        check("mix.xrdata", {16'd0, x_rdata}, 32'hBEEF);
        check("mix.drhold", {16'd0, d_rdata}, 32'h1234);
        tick();
        check("mix.pulse", {30'd0, d_rvalid, x_rvalid}, 32'b00);

        // Starvation: D held; X wins on cycles 5 and 11 (x_req dropped on 6).
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        x_we = 1'b0; x_addr = 16'h0050;
        for (int c = 1; c <= 11; c++) begin
            logic exp_x;
            exp_x = (c == 5) || (c == 11);
            x_req = (c != 6);
            #1;
            check($sformatf("starve.c%0d.grant", c), {30'd0, d_stall, x_gnt}, {30'd0, exp_x, exp_x});
            tick();
            check($sformatf("starve.c%0d.bus", c), {15'd0, MemRead, MemAddr},
                  {15'd0, 1'b1, (exp_x ? 16'h0050 : 16'h0040)});
        end
        d_req = 1'b0; x_req = 1'b0;
        tick();
        tick();

        // Alternating D/X reads, one per cycle, no bubbles.
        for (int i = 0; i <= 6; i++) begin
            d_req = (i < 6) && (i % 2 == 0);
            x_req = (i < 6) && (i % 2 == 1);
            d_addr = alt_addr(i);
            x_addr = alt_addr(i);
            #1;
            if (i < 6) check($sformatf("alt.%0d.grant", i), {30'd0, d_stall, x_gnt},
                             {30'd0, 1'b0, (i % 2 == 1)});
            tick();
            check($sformatf("alt.%0d.memread", i), {31'd0, MemRead}, {31'd0, (i < 6)});
            if (i < 6) check($sformatf("alt.%0d.addr", i), {16'd0, MemAddr}, {16'd0, alt_addr(i)});
            if (i >= 1) begin
                if ((i - 1) % 2 == 0) begin
                    check($sformatf("alt.%0d.rv", i), {30'd0, d_rvalid, x_rvalid}, 32'b10);
                    check($sformatf("alt.%0d.rd", i), {16'd0, d_rdata}, {16'd0, alt_addr(i - 1) + 16'h1});
                end else begin
                    check($sformatf("alt.%0d.rv", i), {30'd0, d_rvalid, x_rvalid}, 32'b01);
                    check($sformatf("alt.%0d.rd", i), {16'd0, x_rdata}, {16'd0, alt_addr(i - 1) + 16'h1});
                end
            end
        end
        d_req = 1'b0; x_req = 1'b0;
        tick();

        // Reset between MemRead and data return discards the read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
        tick();
        d_req = 1'b0;
        check("rstmid.memread", {31'd0, MemRead}, 32'd1);
        #1 RST = 1'b0;
        #1 check_all_zero("rstmid.async");
        RST = 1'b1;
        tick();
        check("rstmid.norv1", {30'd0, d_rvalid, x_rvalid}, 32'b00);
        tick();
        check("rstmid.norv2", {30'd0, d_rvalid, x_rvalid}, 32'b00);
        d_req = 1'b1; d_addr = 16'h0070;
        tick();
        d_req = 1'b0;
        check("rstmid.newread", {15'd0, MemRead, MemAddr}, {15'd0, 1'b1, 16'h0070});
        tick();
        check("rstmid.rv", {30'd0, d_rvalid, x_rvalid}, 32'b10);
        check("rstmid.rd", {16'd0, d_rdata}, 32'h0071);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
